tdc_cal_pulser: RTL and testbench
=================================

// Module: tdc_cal_pulser
// PURPOSE
//  Calibration pulse source for the fine-time TDC channels: generates DIn-style hit pulses
//  on the 50 MHz clock domain, with programmable period, width and count.
//  Drives a 5-bit fine-slot code (0..31) to the external delay chip so every TDC slice can be
//  exercised (code-density / window calibration). Programmed over the local bus; DataOut is OR-combined.
// PARAMETERS
//  BASE    8'hF0  local-bus base address; registers occupy BASE+0..BASE+3
//  PER_RST 16'd50 reset value of PERIOD (clocks)
// PORTS
//  clk       in   1   50 MHz system clock (clk[2] domain); sole clock
//  rst       in   1   synchronous, active-high reset
//  DataIn    in   32  local-bus write data
//  Address   in   8   local-bus address
//  Read      in   1   local-bus read strobe
//  Write     in   1   local-bus write strobe
//  DataOut   out  32  read data; 32'h0 unless Read && Address in BASE..BASE+3
//  PulseOut  out  1   calibration hit pulse toward TDC DIn
//  FineCode  out  5   delay-chip slot code, stable before/through each pulse
//  FineStb   out  1   one-cycle load strobe for delay chip
//  Busy      out  1   sequence running
// BEHAVIOUR
//  Reset: all outputs 0; CTRL=0, PERIOD=PER_RST, COUNT=1; FSM IDLE; Done=0; sent=0.
//  Regs: +0 CTRL [0]start(W1, self-clear) [1]abort(W1) [2]sweep [7:3]code0 [15:8]width
//        +1 PERIOD[15:0]; +2 COUNT[15:0] (0 = continuous); +3 STATUS RO {sent[15:0],13'b0,Done,Busy,1'b0}.
//  DataOut combinational from Read/Address; writes take effect the clock after Write.
//  FSM IDLE->ARM->PULSE->GAP->(ARM | DONE_S->IDLE).
//   IDLE: start latches width,period,count,code0 into working regs; Done<=0; sent<=0; ->ARM.
//   ARM (1 cycle): FineCode updated, FineStb=1. ->PULSE.
//   PULSE: PulseOut=1 for w cycles, w = (width==0)?1:width. sent++ at pulse end.
//   GAP: wait until period counter reaches eff_per; eff_per = max(PERIOD, w+2).
//        Rising-edge-to-rising-edge spacing = eff_per exactly. Then ->DONE_S if sent==count
//        (count!=0), else ->ARM.
//   DONE_S: Done<=1 (sticky until next start or rst), Busy<=0, ->IDLE.
//  Latency: Write of start in cycle N -> FineStb in N+2, PulseOut rises N+3.
//  FineCode: non-sweep = code0 every pulse; sweep = code0 first, +1 mod 32 per pulse (31->0).
//  Busy = 1 in ARM/PULSE/GAP.
//  Abort: in any state -> IDLE next cycle, PulseOut forced 0 same edge, Done stays 0.
//  Abort+start in one write: abort wins, start ignored. Start while Busy ignored.
//  Reg writes while Busy affect only the next start.
//  sent saturates at 16'hFFFF; continuous mode never sets Done.
//  rst mid-pulse: PulseOut 0 on the next edge, no truncated-pulse recovery.
// CONFIGURATION
//  CAL_PRBS_EN defined: in sweep mode FineCode advances via a 5-bit maximal LFSR (x^5+x^3+1),
//   seeded with code0 (seed 0 replaced by 5'h1F); visits 31 nonzero codes.
//  Not defined: linear increment as above; LFSR logic absent.
// STRUCTURE
//  Package tdc_cal_pkg: register offsets (CAL_CTRL=0, CAL_PER=1, CAL_CNT=2, CAL_STAT=3),
//   FSM state enum, CTRL bit positions, LFSR polynomial constant.
//  Sub-module tdc_cal_regs: bus decode, CTRL/PERIOD/COUNT storage, STATUS mux, start/abort pulses.
//  Top: FSM, width/period/pulse counters, FineCode generator.
// TESTING
//  1 PERIOD=10,COUNT=3,width=2,code0=5,no sweep,start -> 3 pulses, 2 clk high, rises 10 apart; FineCode=5; Done=1.
//  2 sweep,code0=30,COUNT=4 -> FineCode 30,31,0,1; FineStb 1 clk before each rise.
//  3 PERIOD=2,width=4 -> spacing clamps to 6; width=0 -> 1-clk pulses.
//  4 COUNT=0 continuous, abort after 5 pulses -> PulseOut 0 next edge, Busy 0, Done 0, sent=5.
//  5 Read BASE+3 during run -> Busy=1; Read BASE+4 -> DataOut 0; write start+abort together -> stays IDLE.
//  6 rst asserted mid-PULSE -> all outputs 0, regs at reset values; CAL_PRBS_EN build: 31 distinct codes.

Source files
------------

// File: rtl/tdc_cal_pkg.sv
// Shared definitions for the TDC calibration pulser: register map, FSM states, CTRL layout, LFSR.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package tdc_cal_pkg;

    // Register offsets relative to the block base address
    localparam logic [1:0] CAL_CTRL = 2'd0;
    localparam logic [1:0] CAL_PER  = 2'd1;
    localparam logic [1:0] CAL_CNT  = 2'd2;
    localparam logic [1:0] CAL_STAT = 2'd3;

    // CTRL bit positions
    localparam int CTRL_START     = 0;
    localparam int CTRL_ABORT     = 1;
    localparam int CTRL_SWEEP     = 2;
    localparam int CTRL_CODE_LSB  = 3;
    localparam int CTRL_WIDTH_LSB = 8;

    // x^5 + x^3 + 1: feedback taps on bits 4 and 2 of a left-shifting register
    localparam logic [4:0] LFSR_POLY  = 5'b10100;
    // An all-zero LFSR state locks up, so a zero seed is replaced by this value
    localparam logic [4:0] LFSR_SEED0 = 5'h1F;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } cal_state_e;

    // Persistent (non-strobe) part of CTRL
    typedef struct packed {
        logic [7:0] width;
        logic [4:0] code0;
        logic       sweep;
    } cal_ctrl_t;

    function automatic logic [4:0] lfsr_next(input logic [4:0] q);
        return {q[3:0], ^(q & LFSR_POLY)};
    endfunction

endpackage

// File: rtl/tdc_cal_pulser_if.sv
// Local-bus interface of the calibration pulser (write strobe, read strobe, address, data).
// Latency: writes land the clock after Write; DataOut is combinational from Read/Address.
// Backpressure: none; the bus is always accepted.
// Signals: DataIn[31:0], Address[7:0], Read, Write (master->slave); DataOut[31:0] (slave->master).
interface tdc_cal_pulser_if;
    logic [31:0] DataIn;
    logic [7:0]  Address;
    logic        Read;
    logic        Write;
    logic [31:0] DataOut;

    modport master (output DataIn, output Address, output Read, output Write, input DataOut);
    modport slave  (input DataIn, input Address, input Read, input Write, output DataOut);
endinterface

// File: rtl/tdc_cal_regs.sv
// Bus decode and register file: CTRL/PERIOD/COUNT storage, STATUS read mux, start/abort strobes.
// Latency: register writes and start/abort strobes appear 1 clk after Write; reads are combinational.
// Backpressure: none; every bus access completes in its own cycle.
// Ports: clk, rst (sync, active-high); bus (slave modport); ctrl_o/period_o/count_o configuration;
//        start_o/abort_o one-cycle strobes; busy_i/done_i/sent_i status from the sequencer.
module tdc_cal_regs
    import tdc_cal_pkg::*;
#(
    parameter logic [7:0]  BASE    = 8'hF0,
    parameter logic [15:0] PER_RST = 16'd50
) (
    input  logic                    clk,
    input  logic                    rst,
    tdc_cal_pulser_if.slave         bus,
    output cal_ctrl_t               ctrl_o,
    output logic [15:0]             period_o,
    output logic [15:0]             count_o,
    output logic                    start_o,
    output logic                    abort_o,
    input  logic                    busy_i,
    input  logic                    done_i,
    input  logic [15:0]             sent_i
);

    cal_ctrl_t   ctrl_q, ctrl_d;
    logic [15:0] period_q, period_d;
    logic [15:0] count_q, count_d;
    logic        start_q, start_d;
    logic        abort_q, abort_d;

    // Offset from BASE; the subtraction keeps the decode correct for unaligned bases
    logic [7:0] off;
    logic       hit;
    logic       wr_en;
    logic       unused_hi;

    assign off       = bus.Address - BASE;
    assign hit       = (off < 8'd4);
    assign wr_en     = bus.Write && hit;
    assign unused_hi = ^bus.DataIn[31:16];

    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        count_d  = count_q;
        start_d  = 1'b0;
        abort_d  = 1'b0;
        if (wr_en) begin
            case (off[1:0])
                CAL_CTRL: begin
                    ctrl_d.width = bus.DataIn[CTRL_WIDTH_LSB +: 8];
                    ctrl_d.code0 = bus.DataIn[CTRL_CODE_LSB +: 5];
                    ctrl_d.sweep = bus.DataIn[CTRL_SWEEP];
                    abort_d      = bus.DataIn[CTRL_ABORT];
                    // abort takes priority over a start in the same write
                    start_d      = bus.DataIn[CTRL_START] & ~bus.DataIn[CTRL_ABORT];
                end
                CAL_PER:  period_d = bus.DataIn[15:0];
                CAL_CNT:  count_d  = bus.DataIn[15:0];
                default:  ;  // STATUS is read-only
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            period_q <= PER_RST;
            count_q  <= 16'd1;
            start_q  <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            count_q  <= count_d;
            start_q  <= start_d;
            abort_q  <= abort_d;
        end
    end

    // start/abort are strobes and always read back as 0
    always_comb begin
        bus.DataOut = 32'h0;
        if (bus.Read && hit) begin
            case (off[1:0])
                CAL_CTRL: bus.DataOut = {16'h0, ctrl_q.width, ctrl_q.code0, ctrl_q.sweep, 2'b00};
                CAL_PER:  bus.DataOut = {16'h0, period_q};
                CAL_CNT:  bus.DataOut = {16'h0, count_q};
                default:  bus.DataOut = {sent_i, 13'h0, done_i, busy_i, 1'b0};
            endcase
        end
    end

    assign ctrl_o   = ctrl_q;
    assign period_o = period_q;
    assign count_o  = count_q;
    assign start_o  = start_q;
    assign abort_o  = abort_q;

endmodule

// File: rtl/tdc_cal_pulser.sv
// Calibration pulse source for fine-time TDC channels: programmable period/width/count, 5-bit slot code.
// Latency: start written in cycle N -> FineStb in N+2, PulseOut rises in N+3; abort -> IDLE 2 clks after Write.
// Backpressure: none; start while busy is dropped, register writes while busy apply to the next start.
// Ports: clk, rst (sync, active-high); bus (local-bus slave); PulseOut hit pulse; FineCode/FineStb to the
//        delay chip; Busy while a sequence runs.
// Build option: define CAL_PRBS_EN to step FineCode through a 5-bit maximal LFSR in sweep mode.
module tdc_cal_pulser
    import tdc_cal_pkg::*;
#(
    parameter logic [7:0]  BASE    = 8'hF0,
    parameter logic [15:0] PER_RST = 16'd50
) (
    input  logic            clk,
    input  logic            rst,
    tdc_cal_pulser_if.slave bus,
    output logic            PulseOut,
    output logic [4:0]      FineCode,
    output logic            FineStb,
    output logic            Busy
);

    cal_ctrl_t   ctrl;
    logic [15:0] period;
    logic [15:0] count;
    logic        start;
    logic        abort;

    cal_state_e  state_q, state_d;
    logic [16:0] cnt_q, cnt_d;        // clocks since the current pulse rose
    logic [7:0]  w_q, w_d;            // effective pulse width
    logic [16:0] eff_q, eff_d;        // effective rise-to-rise period
    logic [15:0] lim_q, lim_d;        // pulse count, 0 = continuous
    logic        sweep_q, sweep_d;
    logic [4:0]  code_q, code_d;
    logic [15:0] sent_q, sent_d;
    logic        done_q, done_d;

    logic        busy;

    tdc_cal_regs #(
        .BASE    (BASE),
        .PER_RST (PER_RST)
    ) u_regs (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ctrl_o   (ctrl),
        .period_o (period),
        .count_o  (count),
        .start_o  (start),
        .abort_o  (abort),
        .busy_i   (busy),
        .done_i   (done_q),
        .sent_i   (sent_q)
    );

    // Start-time derived parameters. The period is clamped to w+2 so there is always at
    // least one GAP cycle plus the ARM cycle between pulses.
    logic [7:0]  w_start;
    logic [16:0] wp2_start;
    logic [16:0] per_start;
    logic [16:0] eff_start;
    logic [4:0]  code_first;
    logic [4:0]  code_step;

    assign w_start   = (ctrl.width == 8'd0) ? 8'd1 : ctrl.width;
    assign wp2_start = {9'd0, w_start} + 17'd2;
    assign per_start = {1'b0, period};
    assign eff_start = (per_start > wp2_start) ? per_start : wp2_start;

`ifdef CAL_PRBS_EN
    assign code_first = (ctrl.sweep && ctrl.code0 == 5'd0) ? LFSR_SEED0 : ctrl.code0;
    assign code_step  = sweep_q ? lfsr_next(code_q) : code_q;
`else
    assign code_first = ctrl.code0;
    assign code_step  = sweep_q ? code_q + 5'd1 : code_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        w_d     = w_q;
        eff_d   = eff_q;
        lim_d   = lim_q;
        sweep_d = sweep_q;
        code_d  = code_q;
        sent_d  = sent_q;
        done_d  = done_q;

        case (state_q)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_d     = w_start;
                    eff_d   = eff_start;
                    lim_d   = count;
                    sweep_d = ctrl.sweep;
                    code_d  = code_first;
                    sent_d  = 16'd0;
                    done_d  = 1'b0;
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                cnt_d   = 17'd0;
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                cnt_d = cnt_q + 17'd1;
                if (cnt_q == {9'd0, w_q - 8'd1}) begin
                    sent_d  = (sent_q == 16'hFFFF) ? sent_q : sent_q + 16'd1;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_q + 17'd1;
                // leave one cycle early: the ARM cycle completes the period
                if (cnt_q == eff_q - 17'd2) begin
                    if (lim_q != 16'd0 && sent_q == lim_q) begin
                        state_d = ST_DONE;
                    end else begin
                        code_d  = code_step;
                        state_d = ST_ARM;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            w_q     <= 8'd1;
            eff_q   <= 17'd3;
            lim_q   <= 16'd1;
            sweep_q <= 1'b0;
            code_q  <= '0;
            sent_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
            eff_q   <= eff_d;
            lim_q   <= lim_d;
            sweep_q <= sweep_d;
            code_q  <= code_d;
            sent_q  <= sent_d;
            done_q  <= done_d;
        end
    end

    assign busy     = (state_q == ST_ARM) || (state_q == ST_PULSE) || (state_q == ST_GAP);
    assign Busy     = busy;
    assign PulseOut = (state_q == ST_PULSE);
    assign FineStb  = (state_q == ST_ARM);
    assign FineCode = code_q;

endmodule

// File: tb/tb_tdc_cal_pulser.sv
// Self-checking bench for tdc_cal_pulser: timing model per cycle plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_tdc_cal_pulser;

    localparam logic [7:0] BASE = 8'hF0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       PulseOut;
    logic [4:0] FineCode;
    logic       FineStb;
    logic       Busy;

    tdc_cal_pulser_if bus ();

    tdc_cal_pulser #(.BASE(8'hF0), .PER_RST(16'd50)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .PulseOut (PulseOut),
        .FineCode (FineCode),
        .FineStb  (FineStb),
        .Busy     (Busy)
    );

    always #10 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A run started by a write in cycle T produces, for pulse k, a strobe at T+2+k*eff
    // and a pulse high over T+3+k*eff .. T+2+k*eff+w; Busy covers T+2 .. T+1+n*eff.
    bit   m_on    = 1'b0;
    int   m_T     = 0;
    int   m_n     = 0;
    int   m_eff   = 3;
    int   m_w     = 1;
    int   m_code0 = 0;
    bit   m_sweep = 1'b0;
    int   m_stop  = 0;
    int   sh_per  = 50;
    int   sh_cnt  = 1;

    function automatic int exp_code(input int k);
        logic [4:0] q;
        if (!m_sweep) return m_code0;
`ifdef CAL_PRBS_EN
        q = (m_code0 == 0) ? 5'h1F : m_code0[4:0];
        for (int i = 0; i < k; i++) q = {q[3:0], q[4] ^ q[2]};
        return int'(q);
`else
        q = 5'd0;
        return (m_code0 + k + int'(q)) % 32;
`endif
    endfunction

    bit   chk_en = 1'b0;
    logic prev_p = 1'b0;
    int   rises[$];
    int   rcodes[$];

    always @(negedge clk) begin
        int  rel;
        int  k;
        int  ph;
        bit  act;
        bit  e_p;
        bit  e_s;
        rel = cyc - m_T - 2;
        act = m_on && rel >= 0 && cyc < m_stop && (m_n == 0 || rel < m_n * m_eff);
        k   = act ? rel / m_eff : 0;
        ph  = act ? rel % m_eff : 0;
        e_s = act && ph == 0;
        e_p = act && ph >= 1 && ph <= m_w;
        if (chk_en) begin
            check("PulseOut", {31'd0, PulseOut}, {31'd0, e_p});
            check("FineStb", {31'd0, FineStb}, {31'd0, e_s});
            check("Busy", {31'd0, Busy}, {31'd0, act});
            if (e_s || e_p) check("FineCode", {27'd0, FineCode}, exp_code(k));
        end
        if (PulseOut === 1'b1 && prev_p === 1'b0) begin
            rises.push_back(cyc);
            rcodes.push_back(int'(FineCode));
        end
        prev_p = PulseOut;
    end

    // ---------------- bus tasks ----------------
    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        bus.Address = a;
        bus.DataIn  = d;
        bus.Write   = 1'b1;
        if (a == BASE + 8'd1) sh_per = int'(d[15:0]);
        if (a == BASE + 8'd2) sh_cnt = int'(d[15:0]);
        if (a == BASE && d[1] && m_on && m_stop > cyc + 2) m_stop = cyc + 2;
        if (a == BASE && d[0] && !d[1]) begin
            m_on    = 1'b1;
            m_T     = cyc;
            m_n     = sh_cnt;
            m_w     = (d[15:8] == 8'd0) ? 1 : int'(d[15:8]);
            m_eff   = (sh_per > m_w + 2) ? sh_per : m_w + 2;
            m_code0 = int'(d[7:3]);
            m_sweep = d[2];
            m_stop  = 32'h7FFF_FFFF;
        end
        @(posedge clk); #1;
        bus.Write = 1'b0;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        bus.Address = a;
        bus.Read    = 1'b1;
        @(negedge clk);
        d = bus.DataOut;
        #1;
        bus.Read = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          t0;
        int          a;
        logic [31:0] seen;
        bus.DataIn  = '0;
        bus.Address = '0;
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;

        // reset state
        check("rst_pulse", {31'd0, PulseOut}, 32'd0);
        check("rst_stb", {31'd0, FineStb}, 32'd0);
        check("rst_code", {27'd0, FineCode}, 32'd0);
        check("rst_busy", {31'd0, Busy}, 32'd0);
        bus_rd(BASE, rd);         check("rst_ctrl", rd, 32'h0);
        bus_rd(BASE + 8'd1, rd);  check("rst_per", rd, 32'd50);
        bus_rd(BASE + 8'd2, rd);  check("rst_cnt", rd, 32'd1);
        bus_rd(BASE + 8'd3, rd);  check("rst_stat", rd, 32'h0);

        // 1: fixed code, 3 pulses, width 2, period 10
        bus_wr(BASE + 8'd1, 32'd10);
        bus_wr(BASE + 8'd2, 32'd3);
        bus_rd(BASE + 8'd1, rd);  check("t1_per_rb", rd, 32'd10);
        rises.delete(); rcodes.delete();
        bus_wr(BASE, (32'd2 << 8) | (32'd5 << 3) | 32'd1);
        t0 = m_T;
        idle(36);
        check("t1_npulse", rises.size(), 32'd3);
        if (rises.size() == 3) begin
            check("t1_latency", rises[0] - t0, 32'd3);
            check("t1_space0", rises[1] - rises[0], 32'd10);
            check("t1_space1", rises[2] - rises[1], 32'd10);
            for (int i = 0; i < 3; i++) check("t1_code", rcodes[i], 32'd5);
        end
        bus_rd(BASE + 8'd3, rd);  check("t1_stat", rd, 32'h0003_0004);

        // 2: sweep from 30, 4 pulses
        bus_wr(BASE + 8'd1, 32'd8);
        bus_wr(BASE + 8'd2, 32'd4);
        rises.delete(); rcodes.delete();
        bus_wr(BASE, (32'd1 << 8) | (32'd30 << 3) | 32'd4 | 32'd1);
        idle(4 * 8 + 6);
        check("t2_npulse", rises.size(), 32'd4);
        if (rises.size() == 4) begin
`ifdef CAL_PRBS_EN
            check("t2_code0", rcodes[0], 32'd30);
            check("t2_code1", rcodes[1], 32'd28);
`else
            check("t2_code0", rcodes[0], 32'd30);
            check("t2_code1", rcodes[1], 32'd31);
            check("t2_code2", rcodes[2], 32'd0);
            check("t2_code3", rcodes[3], 32'd1);
`endif
        end

        // 3: period clamp and zero width
        bus_wr(BASE + 8'd1, 32'd2);
        bus_wr(BASE + 8'd2, 32'd2);
        rises.delete(); rcodes.delete();
        bus_wr(BASE, (32'd4 << 8) | 32'd1);
        idle(2 * 6 + 6);
        check("t3_npulse", rises.size(), 32'd2);
        if (rises.size() == 2) check("t3_clamp6", rises[1] - rises[0], 32'd6);
        rises.delete(); rcodes.delete();
        bus_wr(BASE, 32'd1);
        idle(2 * 3 + 6);
        check("t3b_npulse", rises.size(), 32'd2);
        if (rises.size() == 2) check("t3b_clamp3", rises[1] - rises[0], 32'd3);

        // 4: continuous, abort during the gap after the fifth pulse
        bus_wr(BASE + 8'd1, 32'd6);
        bus_wr(BASE + 8'd2, 32'd0);
        rises.delete(); rcodes.delete();
        bus_wr(BASE, (32'd1 << 8) | 32'd1);
        t0 = m_T;
        a  = t0 + 5 * 6 - 2;
        idle(a - cyc - 1);
        bus_wr(BASE, 32'd2);
        idle(4);
        check("t4_busy", {31'd0, Busy}, 32'd0);
        check("t4_npulse", rises.size(), 32'd5);
        bus_rd(BASE + 8'd3, rd);  check("t4_stat", rd, 32'h0005_0000);

        // 5: status during a run, out-of-range read, start+abort together
        bus_wr(BASE + 8'd1, 32'd20);
        bus_wr(BASE + 8'd2, 32'd1);
        bus_wr(BASE, (32'd3 << 8) | 32'd1);
        bus_rd(BASE + 8'd3, rd);  check("t5_busybit", {31'd0, rd[1]}, 32'd1);
        bus_rd(BASE + 8'd4, rd);  check("t5_oor_hi", rd, 32'h0);
        bus_rd(BASE - 8'd1, rd);  check("t5_oor_lo", rd, 32'h0);
        idle(26);
        bus_wr(BASE, 32'd3);
        idle(5);
        check("t5_noidle", {31'd0, Busy}, 32'd0);
        bus_rd(BASE + 8'd3, rd);  check("t5_stat", rd, 32'h0001_0004);
        bus_rd(BASE, rd);         check("t5_ctrl", rd, 32'h0);

        // 6: reset in the middle of a pulse
        bus_wr(BASE + 8'd1, 32'd20);
        bus_wr(BASE + 8'd2, 32'd2);
        bus_wr(BASE, (32'd5 << 8) | (32'd9 << 3) | 32'd1);
        idle(2);
        @(posedge clk); #1;
        check("t6_midpulse", {31'd0, PulseOut}, 32'd1);
        rst = 1'b1;
        if (m_stop > cyc + 1) m_stop = cyc + 1;
        sh_per = 50; sh_cnt = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_on = 1'b0;
        check("t6_pulse", {31'd0, PulseOut}, 32'd0);
        check("t6_code", {27'd0, FineCode}, 32'd0);
        check("t6_busy", {31'd0, Busy}, 32'd0);
        bus_rd(BASE, rd);         check("t6_ctrl", rd, 32'h0);
        bus_rd(BASE + 8'd1, rd);  check("t6_per", rd, 32'd50);
        bus_rd(BASE + 8'd2, rd);  check("t6_cnt", rd, 32'd1);
        bus_rd(BASE + 8'd3, rd);  check("t6_stat", rd, 32'h0);

`ifdef CAL_PRBS_EN
        // LFSR sweep from a zero seed must visit all 31 nonzero codes
        bus_wr(BASE + 8'd1, 32'd3);
        bus_wr(BASE + 8'd2, 32'd31);
        rises.delete(); rcodes.delete();
        bus_wr(BASE, (32'd1 << 8) | 32'd4 | 32'd1);
        idle(31 * 3 + 6);
        check("prbs_npulse", rises.size(), 32'd31);
        seen = 32'h0;
        foreach (rcodes[i]) seen[rcodes[i][4:0]] = 1'b1;
        check("prbs_cover", seen, 32'hFFFF_FFFE);
        if (rcodes.size() > 0) check("prbs_seed", rcodes[0], 32'h1F);
`else
        seen = 32'h0;
`endif

        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
